// File: rtl/cs_resolve_seq.sv
// Sequential carry-save resolver: adds cs_hi and (cs_lo << OFFSET) with a
// CHUNK-bit ripple slice per cycle, handing the W+1 bit sum downstream.
module cs_resolve_seq #(
    parameter int W      = 14,
    parameter int LW     = 10,
    parameter int OFFSET = 2,
    parameter int CHUNK  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] cs_hi,
    input  logic [LW-1:0] cs_lo,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   res,
    output logic [1:0]   dbg_state_o
);

    localparam int NCH = (W + CHUNK - 1) / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW  = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           cy_q, cy_d;
    logic [W:0]     r_q, r_d;

    logic [BW-1:0]  base;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0] csum;
    logic [W:0]     ins, msk;
    logic           last;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready/valid here come only from the state register, never from the peer.
    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign res         = r_q;
    assign dbg_state_o = state_q;

    assign base = BW'(idx_q) * BW'(CHUNK);
    assign last = (idx_q == IW'(NCH - 1));
    // Bits shifted in above W-1 are zero, so a partial top chunk carries out of bit W-1 into res[W].
    assign a_sl = CHUNK'(a_q >> base);
    assign b_sl = CHUNK'(b_q >> base);
    assign csum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, cy_q};
    assign ins  = (W + 1)'(csum) << base;
    assign msk  = (W + 1)'({(CHUNK + 1){1'b1}}) << base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        r_d     = r_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = cs_hi;
                    b_d     = W'(cs_lo) << OFFSET;
                    idx_d   = '0;
                    cy_d    = 1'b0;
                    r_d     = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                // The slice's carry bit is provisional until the next slice overwrites it.
                r_d  = (r_q & ~msk) | ins;
                cy_d = csum[CHUNK];
                if (last) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
